// File: rtl/ppu_spr_pipe.sv
// Sprite evaluation (OAM scan + CHR fetch into a shadow slot bank) and per-pixel sprite render.
// Optional 8x16 sprite support is compiled in when SPR_8X16_EN is defined.
module ppu_spr_pipe #(
   parameter int NUM_SLOTS   = 8,
   parameter int OAM_ENTRIES = 64
) (
   input  logic        PPU_SLOW_CLOCK,
   input  logic        RST,
   input  logic        LINE_START,
   input  logic [7:0]  EVAL_Y,
   input  logic        RENDER_EN,
   input  logic        SPR_BASE,
   input  logic        TALL,
   input  logic        CLR_FLAGS,
   input  logic [7:0]  PIXEL_X,
   output logic [7:0]  OAM_ADDR,
   input  logic [7:0]  OAM_RDATA,
   output logic [12:0] CHR_ADDR,
   input  logic [7:0]  CHR_RDATA,
   output logic [3:0]  SPR_PIX,
   output logic        SPR_OPAQUE,
   output logic        SPR_BEHIND,
   output logic        SPR_ZERO,
   output logic        SPR_ZERO_HIT,
   output logic        OVERFLOW,
   output logic        EVAL_BUSY
);

   localparam logic [4:0] SLOTS_FULL = 5'(NUM_SLOTS);
   localparam logic [5:0] LAST_ENTRY = 6'(OAM_ENTRIES - 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_Y,
      S_CHK,
      S_IDX,
      S_ATTR,
      S_X,
      S_LO,
      S_HI,
      S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [5:0]  n_q, n_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        slot_we;
   logic        ovf_set;

   logic [7:0]  eval_y_q;
   logic [7:0]  idx_q;
   logic [4:0]  attr_q;
   logic [7:0]  x_q;
   logic [7:0]  lo_q;
   logic [3:0]  row_q;
   logic [7:0]  row_chk;
   logic [7:0]  height;
   logic [3:0]  h_m1;
   logic [3:0]  r_fetch;
   logic [12:0] chr_lo_addr;

   logic [7:0]  sh_lo   [NUM_SLOTS];
   logic [7:0]  sh_hi   [NUM_SLOTS];
   logic [7:0]  sh_x    [NUM_SLOTS];
   logic [2:0]  sh_attr [NUM_SLOTS];
   logic [NUM_SLOTS-1:0] sh_zero;
   logic [NUM_SLOTS-1:0] sh_vld;

   logic [7:0]  ac_lo   [NUM_SLOTS];
   logic [7:0]  ac_hi   [NUM_SLOTS];
   logic [7:0]  ac_x    [NUM_SLOTS];
   logic [2:0]  ac_attr [NUM_SLOTS];
   logic [NUM_SLOTS-1:0] ac_zero;
   logic [NUM_SLOTS-1:0] ac_vld;

   logic [NUM_SLOTS-1:0] slot_sel;

   logic        vld_p0, behind_p0, zero_p0;
   logic [3:0]  pix_p0;
   logic        vld_p1, behind_p1, zero_p1;
   logic [3:0]  pix_p1;
   logic [7:0]  col;
   logic [1:0]  colour;

   function automatic logic [7:0] hflip_bits(input logic [7:0] v, input logic flip);
      logic [7:0] rev;
      for (int i = 0; i < 8; i++) begin
         rev[i] = v[7-i];
      end
      return flip ? rev : v;
   endfunction

`ifdef SPR_8X16_EN
   logic tall_q;

   always_ff @(posedge PPU_SLOW_CLOCK) begin
      if (LINE_START) begin
         tall_q <= TALL;
      end
   end

   assign height = tall_q ? 8'd16 : 8'd8;
   assign h_m1   = tall_q ? 4'd15 : 4'd7;

   always_comb begin
      r_fetch = attr_q[4] ? (h_m1 - row_q) : row_q;
      if (tall_q) begin
         chr_lo_addr = {idx_q[0], idx_q[7:1], r_fetch[3], 1'b0, r_fetch[2:0]};
      end else begin
         chr_lo_addr = {SPR_BASE, idx_q, 1'b0, r_fetch[2:0]};
      end
   end
`else
   logic unused_cfg;

   assign height     = 8'd8;
   assign h_m1       = 4'd7;
   assign unused_cfg = ^{TALL, r_fetch[3]};

   always_comb begin
      r_fetch     = attr_q[4] ? (h_m1 - row_q) : row_q;
      chr_lo_addr = {SPR_BASE, idx_q, 1'b0, r_fetch[2:0]};
   end
`endif

   always_comb begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
         slot_sel[s] = (cnt_q == 5'(s));
      end
   end

   always_comb begin
      state_d  = state_q;
      n_d      = n_q;
      cnt_d    = cnt_q;
      slot_we  = 1'b0;
      ovf_set  = 1'b0;
      OAM_ADDR = 8'h00;
      CHR_ADDR = 13'h0000;
      row_chk  = eval_y_q - OAM_RDATA;
      case (state_q)
         S_Y: begin
            OAM_ADDR = {n_q, 2'd0};
            state_d  = S_CHK;
         end
         S_CHK: begin
            OAM_ADDR = {n_q, 2'd1};
            if ((row_chk < height) && (OAM_RDATA < 8'hEF)) begin
               if (cnt_q == SLOTS_FULL) begin
                  ovf_set = 1'b1;
                  state_d = S_DONE;
               end else begin
                  state_d = S_IDX;
               end
            end else if (n_q == LAST_ENTRY) begin
               state_d = S_DONE;
            end else begin
               n_d     = n_q + 6'd1;
               state_d = S_Y;
            end
         end
         S_IDX: begin
            OAM_ADDR = {n_q, 2'd2};
            state_d  = S_ATTR;
         end
         S_ATTR: begin
            OAM_ADDR = {n_q, 2'd3};
            state_d  = S_X;
         end
         S_X: begin
            CHR_ADDR = chr_lo_addr;
            state_d  = S_LO;
         end
         S_LO: begin
            CHR_ADDR = chr_lo_addr | 13'h0008;
            state_d  = S_HI;
         end
         S_HI: begin
            slot_we = 1'b1;
            cnt_d   = cnt_q + 5'd1;
            if (n_q == LAST_ENTRY) begin
               state_d = S_DONE;
            end else begin
               n_d     = n_q + 6'd1;
               state_d = S_Y;
            end
         end
         default: ;
      endcase
      // A new line pre-empts whatever the scan was doing; an unfinished slot is dropped.
      if (LINE_START) begin
         slot_we = 1'b0;
         ovf_set = 1'b0;
         n_d     = 6'd0;
         cnt_d   = 5'd0;
         state_d = RENDER_EN ? S_Y : S_IDLE;
      end
   end

   assign EVAL_BUSY = (state_q != S_IDLE) && (state_q != S_DONE);

   always_ff @(posedge PPU_SLOW_CLOCK or posedge RST) begin
      if (RST) begin
         state_q      <= S_IDLE;
         n_q          <= 6'd0;
         cnt_q        <= 5'd0;
         sh_vld       <= '0;
         ac_vld       <= '0;
         OVERFLOW     <= 1'b0;
         SPR_ZERO_HIT <= 1'b0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         cnt_q   <= cnt_d;
         if (LINE_START) begin
            ac_vld <= RENDER_EN ? sh_vld : '0;
            sh_vld <= '0;
         end else if (slot_we) begin
            sh_vld <= sh_vld | slot_sel;
         end
         if (ovf_set) begin
            OVERFLOW <= 1'b1;
         end else if (CLR_FLAGS) begin
            OVERFLOW <= 1'b0;
         end
         if (zero_p1 && vld_p1) begin
            SPR_ZERO_HIT <= 1'b1;
         end else if (CLR_FLAGS) begin
            SPR_ZERO_HIT <= 1'b0;
         end
      end
   end

   always_ff @(posedge PPU_SLOW_CLOCK) begin
      if (LINE_START) begin
         eval_y_q <= EVAL_Y;
      end
      if (state_q == S_CHK) begin
         row_q <= row_chk[3:0];
      end
      if (state_q == S_IDX) begin
         idx_q <= OAM_RDATA;
      end
      if (state_q == S_ATTR) begin
         attr_q <= {OAM_RDATA[7:5], OAM_RDATA[1:0]};
      end
      if (state_q == S_X) begin
         x_q <= OAM_RDATA;
      end
      if (state_q == S_LO) begin
         lo_q <= CHR_RDATA;
      end
      for (int s = 0; s < NUM_SLOTS; s++) begin
         if (LINE_START) begin
            ac_lo[s]   <= sh_lo[s];
            ac_hi[s]   <= sh_hi[s];
            ac_x[s]    <= sh_x[s];
            ac_attr[s] <= sh_attr[s];
            ac_zero[s] <= sh_zero[s];
         end
         if (slot_we && slot_sel[s]) begin
            sh_lo[s]   <= hflip_bits(lo_q, attr_q[3]);
            sh_hi[s]   <= hflip_bits(CHR_RDATA, attr_q[3]);
            sh_x[s]    <= x_q;
            sh_attr[s] <= attr_q[2:0];
            sh_zero[s] <= (n_q == 6'd0);
         end
      end
   end

   // p0: combinational slot match; the lowest opaque slot wins.
   always_comb begin
      vld_p0    = 1'b0;
      pix_p0    = 4'h0;
      behind_p0 = 1'b0;
      zero_p0   = 1'b0;
      col       = 8'h00;
      colour    = 2'b00;
      for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
         col    = PIXEL_X - ac_x[s];
         colour = {ac_hi[s][~col[2:0]], ac_lo[s][~col[2:0]]};
         if (ac_vld[s] && (col < 8'd8) && (colour != 2'b00)) begin
            vld_p0    = 1'b1;
            pix_p0    = {ac_attr[s][1:0], colour};
            behind_p0 = ac_attr[s][2];
            zero_p0   = ac_zero[s];
         end
      end
   end

   // p1: registered pixel outputs.
   always_ff @(posedge PPU_SLOW_CLOCK or posedge RST) begin
      if (RST) begin
         vld_p1    <= 1'b0;
         pix_p1    <= 4'h0;
         behind_p1 <= 1'b0;
         zero_p1   <= 1'b0;
      end else begin
         vld_p1    <= vld_p0;
         pix_p1    <= pix_p0;
         behind_p1 <= behind_p0;
         zero_p1   <= zero_p0;
      end
   end

   assign SPR_PIX    = pix_p1;
   assign SPR_OPAQUE = vld_p1;
   assign SPR_BEHIND = behind_p1;
   assign SPR_ZERO   = zero_p1;

endmodule

// File: tb/tb_ppu_spr_pipe.sv
// Directed bench for ppu_spr_pipe with behavioural OAM/CHR memories (1-cycle read latency).
module tb_ppu_spr_pipe;

   logic        PPU_SLOW_CLOCK = 1'b0;
   logic        RST = 1'b1;
   logic        LINE_START = 1'b0;
   logic [7:0]  EVAL_Y = 8'h00;
   logic        RENDER_EN = 1'b0;
   logic        SPR_BASE = 1'b0;
   logic        TALL = 1'b0;
   logic        CLR_FLAGS = 1'b0;
   logic [7:0]  PIXEL_X = 8'h00;
   logic [7:0]  OAM_ADDR;
   logic [7:0]  OAM_RDATA = 8'h00;
   logic [12:0] CHR_ADDR;
   logic [7:0]  CHR_RDATA = 8'h00;
   logic [3:0]  SPR_PIX;
   logic        SPR_OPAQUE, SPR_BEHIND, SPR_ZERO, SPR_ZERO_HIT, OVERFLOW, EVAL_BUSY;

   int tests = 0;
   int fails = 0;

   logic [7:0] oam_mem [256];
   logic [7:0] chr_mem [8192];

   ppu_spr_pipe #(.NUM_SLOTS(8), .OAM_ENTRIES(64)) dut (
      .PPU_SLOW_CLOCK(PPU_SLOW_CLOCK),
      .RST(RST),
      .LINE_START(LINE_START),
      .EVAL_Y(EVAL_Y),
      .RENDER_EN(RENDER_EN),
      .SPR_BASE(SPR_BASE),
      .TALL(TALL),
      .CLR_FLAGS(CLR_FLAGS),
      .PIXEL_X(PIXEL_X),
      .OAM_ADDR(OAM_ADDR),
      .OAM_RDATA(OAM_RDATA),
      .CHR_ADDR(CHR_ADDR),
      .CHR_RDATA(CHR_RDATA),
      .SPR_PIX(SPR_PIX),
      .SPR_OPAQUE(SPR_OPAQUE),
      .SPR_BEHIND(SPR_BEHIND),
      .SPR_ZERO(SPR_ZERO),
      .SPR_ZERO_HIT(SPR_ZERO_HIT),
      .OVERFLOW(OVERFLOW),
      .EVAL_BUSY(EVAL_BUSY)
   );

   always #5 PPU_SLOW_CLOCK = ~PPU_SLOW_CLOCK;

   always @(posedge PPU_SLOW_CLOCK) begin
      OAM_RDATA <= oam_mem[OAM_ADDR];
      CHR_RDATA <= chr_mem[CHR_ADDR];
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: observed no finish, expected finish within 1 ms");
      $fatal(1, "watchdog");
   end

   task automatic step(input int n = 1);
      repeat (n) @(negedge PPU_SLOW_CLOCK);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] pe(input logic [3:0] p, input logic b, input logic z);
      return {25'd0, p, (p[1:0] != 2'b00), b, z};
   endfunction

   function automatic logic [31:0] pix_obs();
      return {25'd0, SPR_PIX, SPR_OPAQUE, SPR_BEHIND, SPR_ZERO};
   endfunction

   task automatic pix(input string tag, input logic [7:0] x, input logic [31:0] exp);
      PIXEL_X = x;
      step();
      check(tag, pix_obs(), exp);
   endtask

   task automatic line_start(input logic [7:0] y, input logic en);
      EVAL_Y     = y;
      RENDER_EN  = en;
      LINE_START = 1'b1;
      step();
      LINE_START = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int k = 0;
      while (EVAL_BUSY && k < 400) begin
         step();
         k++;
      end
      check(tag, 32'(EVAL_BUSY), 32'd0);
   endtask

   task automatic clear_oam();
      for (int i = 0; i < 256; i++) oam_mem[i] = 8'hFF;
   endtask

   task automatic set_spr(input int e, input logic [7:0] y, input logic [7:0] idx,
                          input logic [7:0] attr, input logic [7:0] x);
      oam_mem[8'(4*e)]     = y;
      oam_mem[8'(4*e + 1)] = idx;
      oam_mem[8'(4*e + 2)] = attr;
      oam_mem[8'(4*e + 3)] = x;
   endtask

   function automatic logic [31:0] all_outs();
      return {1'b0, SPR_PIX, SPR_OPAQUE, SPR_BEHIND, SPR_ZERO, SPR_ZERO_HIT,
              OVERFLOW, EVAL_BUSY, OAM_ADDR, CHR_ADDR};
   endfunction

   initial begin
      for (int i = 0; i < 8192; i++) chr_mem[i] = 8'h00;
      clear_oam();
      chr_mem[13'h012] = 8'hC3;  chr_mem[13'h01A] = 8'hA0;
      chr_mem[13'h020] = 8'hFF;  chr_mem[13'h028] = 8'h00;
      chr_mem[13'h040] = 8'hF0;  chr_mem[13'h048] = 8'h00;
      chr_mem[13'h050] = 8'hFF;  chr_mem[13'h058] = 8'hFF;
      chr_mem[13'h066] = 8'h80;  chr_mem[13'h06E] = 8'h01;
      chr_mem[13'h070] = 8'hFF;  chr_mem[13'h078] = 8'hFF;

      RST = 1'b1;
      step(3);
      check("reset_outputs", all_outs(), 32'd0);
      RST = 1'b0;
      step();

      // Sprite 0 at Y=10 X=20 idx 1, evaluated for line 12 (row 2).
      set_spr(0, 8'd10, 8'h01, 8'h00, 8'd20);
      line_start(8'd12, 1'b1);
      check("t1_busy", 32'(EVAL_BUSY), 32'd1);
      check("t1_oam_y", 32'(OAM_ADDR), 32'h00);
      step();
      check("t1_oam_idx", 32'(OAM_ADDR), 32'h01);
      step(3);
      check("t1_chr_lo", 32'(CHR_ADDR), 32'h0012);
      step();
      check("t1_chr_hi", 32'(CHR_ADDR), 32'h001A);
      step(2);
      check("t1_next_entry", 32'(OAM_ADDR), 32'h04);
      wait_idle("t1_eval_done");
      line_start(8'd12, 1'b1);
      pix("t1_px19", 8'd19, pe(4'h0, 1'b0, 1'b0));
      pix("t1_px20", 8'd20, pe(4'h3, 1'b0, 1'b1));
      check("t1_zhit_pending", 32'(SPR_ZERO_HIT), 32'd0);
      pix("t1_px21", 8'd21, pe(4'h1, 1'b0, 1'b1));
      check("t1_zhit_set", 32'(SPR_ZERO_HIT), 32'd1);
      pix("t1_px22", 8'd22, pe(4'h2, 1'b0, 1'b1));
      pix("t1_px23", 8'd23, pe(4'h0, 1'b0, 1'b0));
      pix("t1_px27", 8'd27, pe(4'h1, 1'b0, 1'b1));
      pix("t1_px28", 8'd28, pe(4'h0, 1'b0, 1'b0));
      wait_idle("t1_eval2_done");

      // Nine sprites on line 50 with eight slots.
      clear_oam();
      for (int k = 0; k < 9; k++) set_spr(k, 8'd50, 8'h02, 8'(k & 3), 8'(20 * k));
      line_start(8'd50, 1'b1);
      step(57);
      check("t2_ovf_before", 32'({OVERFLOW, EVAL_BUSY}), 32'h1);
      step();
      check("t2_ovf_after", 32'({OVERFLOW, EVAL_BUSY}), 32'h2);
      CLR_FLAGS = 1'b1;
      step();
      CLR_FLAGS = 1'b0;
      check("t2_clr_flags", 32'({OVERFLOW, SPR_ZERO_HIT}), 32'h0);
      line_start(8'd50, 1'b1);
      pix("t2_slot7", 8'd140, pe(4'hD, 1'b0, 1'b0));
      pix("t2_ninth", 8'd160, pe(4'h0, 1'b0, 1'b0));
      wait_idle("t2_eval2_done");

      // Entries 3 and 5 overlap at X=60.
      clear_oam();
      set_spr(3, 8'd100, 8'h04, 8'h01, 8'd60);
      set_spr(5, 8'd100, 8'h05, 8'h22, 8'd60);
      line_start(8'd100, 1'b1);
      wait_idle("t3_eval_done");
      line_start(8'd100, 1'b1);
      pix("t3_front", 8'd60, pe(4'h5, 1'b0, 1'b0));
      pix("t3_fallthru", 8'd64, pe(4'hB, 1'b1, 1'b0));
      pix("t3_past", 8'd68, pe(4'h0, 1'b0, 1'b0));
      wait_idle("t3_eval2_done");

      // attr 0xC2, row 1: vflip fetch row 6 and hflip output.
      clear_oam();
      set_spr(0, 8'd30, 8'h06, 8'hC2, 8'd100);
      line_start(8'd31, 1'b1);
      step(4);
      check("t4_chr_lo", 32'(CHR_ADDR), 32'h0066);
      step();
      check("t4_chr_hi", 32'(CHR_ADDR), 32'h006E);
      wait_idle("t4_eval_done");
      line_start(8'd31, 1'b1);
      pix("t4_col0", 8'd100, pe(4'hA, 1'b0, 1'b1));
      pix("t4_col7", 8'd107, pe(4'h9, 1'b0, 1'b1));
      pix("t4_col3", 8'd103, pe(4'h0, 1'b0, 1'b0));
      wait_idle("t4_eval2_done");

      // Tall sprite, row 9.
      clear_oam();
      set_spr(0, 8'd40, 8'h03, 8'h00, 8'd200);
      TALL = 1'b1;
      line_start(8'd49, 1'b1);
      TALL = 1'b0;
      step(2);
`ifdef SPR_8X16_EN
      check("t5_tall_hit", 32'(OAM_ADDR), 32'h02);
      step(2);
      check("t5_tall_chr_lo", 32'(CHR_ADDR), 32'h1031);
      step();
      check("t5_tall_chr_hi", 32'(CHR_ADDR), 32'h1039);
`else
      check("t5_tall_miss", 32'(OAM_ADDR), 32'h04);
`endif
      wait_idle("t5_eval_done");
      pix("t5_prev_bank", 8'd100, pe(4'hA, 1'b0, 1'b1));

      // Rendering disabled clears the active bank.
      line_start(8'd0, 1'b0);
      check("t5b_idle", 32'(EVAL_BUSY), 32'd0);
      pix("t5b_cleared", 8'd100, pe(4'h0, 1'b0, 1'b0));

      // Reset during the low-plane fetch.
      clear_oam();
      set_spr(0, 8'd70, 8'h07, 8'h00, 8'd10);
      line_start(8'd70, 1'b1);
      step(5);
      check("t6_in_s_lo", 32'(CHR_ADDR), 32'h0078);
      RST = 1'b1;
      step();
      check("t6_reset_outputs", all_outs(), 32'd0);
      RST = 1'b0;
      line_start(8'd70, 1'b1);
      pix("t6_no_slot", 8'd10, pe(4'h0, 1'b0, 1'b0));
      pix("t6_no_old", 8'd100, pe(4'h0, 1'b0, 1'b0));
      wait_idle("t6_eval_done");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
